// File: rtl/tone_sequencer.sv
// Tone sequencer: plays a writable note table into the square-wave tone generator.
// Optional TONE_SEQ_LOOP_EN: after the last note, wrap to entry 0 and repeat until stopped.
module tone_sequencer #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [23:0]       wr_data_i,
  input  logic [ADDR_W:0]   num_notes_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [15:0]       prescaler_o,
  output logic              tone_ena_o,
  output logic              busy_o,
  output logic              done_o
);
  // state | meaning
  // IDLE  | waiting for start, outputs silent
  // PLAY  | current note sounding for its duration in ticks
  // GAP   | silent gap after a note, prescaler held
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam int CNT_W  = (GAP_W > 8) ? GAP_W : 8;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         presc_q, presc_d;
  logic                ena_q, ena_d;
  logic                done_q, done_d;
  logic [23:0]         table_q [DEPTH];

  logic                tick;
  logic                entry_go;
  logic [ADDR_W-1:0]   entry_idx;
  logic [23:0]         entry;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) table_q[wr_addr_i] <= wr_data_i;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    tick_d    = tick_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    ena_d     = ena_q;
    done_d    = 1'b0;
    entry_go  = 1'b0;
    entry_idx = '0;
    entry     = '0;
    tick      = (tick_q == TICK_W'(TICK_DIV - 1));

    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i && (num_notes_i != '0)) begin
          last_d   = (num_notes_i > (ADDR_W+1)'(DEPTH)) ? ADDR_W'(DEPTH - 1)
                                                        : ADDR_W'(num_notes_i - 1'b1);
          entry_go = 1'b1;
        end
      end
      PLAY, GAP: begin
        if (stop_i) begin
          state_d = IDLE;
          presc_d = '0;
          ena_d   = 1'b0;
          idx_d   = '0;
          tick_d  = '0;
          cnt_d   = '0;
        end else begin
          tick_d = tick ? '0 : tick_q + 1'b1;
          if (tick) begin
            if (cnt_q == CNT_W'(1)) begin
              if ((state_q == PLAY) && (GAP_TICKS > 0)) begin
                state_d = GAP;
                ena_d   = 1'b0;
                tick_d  = '0;
                cnt_d   = CNT_W'(GAP_TICKS);
              end else if (idx_q != last_q) begin
                entry_go  = 1'b1;
                entry_idx = idx_q + 1'b1;
              end else begin
`ifdef TONE_SEQ_LOOP_EN
                entry_go  = 1'b1;
`else
                state_d = IDLE;
                presc_d = '0;
                ena_d   = 1'b0;
                idx_d   = '0;
                tick_d  = '0;
                cnt_d   = '0;
                done_d  = 1'b1;
`endif
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Entry is latched here so later table writes cannot disturb the note in progress.
    if (entry_go) begin
      entry   = table_q[entry_idx];
      state_d = PLAY;
      idx_d   = entry_idx;
      presc_d = entry[15:0];
      ena_d   = |entry[15:0];
      tick_d  = '0;
      cnt_d   = (entry[23:16] == 8'd0) ? CNT_W'(1) : CNT_W'(entry[23:16]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      tick_q  <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      ena_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      ena_q   <= ena_d;
      done_q  <= done_d;
    end
  end

  assign prescaler_o = presc_q;
  assign tone_ena_o  = ena_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: directed cases plus random note tables
// compared cycle by cycle against a note-list waveform model.
module tb_tone_sequencer;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
`ifdef TONE_SEQ_LOOP_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [23:0]       wr_data_i;
  logic [ADDR_W:0]   num_notes_i;
  logic              start_i;
  logic              stop_i;
  logic [15:0]       prescaler_o;
  logic              tone_ena_o;
  logic              busy_o;
  logic              done_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [23:0] tbl [DEPTH];
  logic [18:0] expq [$];

  tone_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .num_notes_i(num_notes_i), .start_i(start_i), .stop_i(stop_i),
    .prescaler_o(prescaler_o), .tone_ena_o(tone_ena_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [18:0] obs();
    return {prescaler_o, tone_ena_o, busy_o, done_o};
  endfunction

  task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed presc/ena/busy/done=%0d/%b/%b/%b expected=%0d/%b/%b/%b",
             tag, o[18:3], o[2], o[1], o[0], e[18:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    wr_en_i = 1'b1; wr_addr_i = ADDR_W'(a); wr_data_i = d;
    step();
    wr_en_i = 1'b0;
    tbl[a] = d;
  endtask

  // Waveform model: each note sounds dur ticks (0 counts as 1) then a silent gap.
  function automatic void build_model(input int num, input bit wr0, input logic [23:0] new0);
    int len;
    logic [23:0] e;
    int d;
    expq.delete();
    len = (num > DEPTH) ? DEPTH : num;
    for (int p = 0; p < PASSES; p++)
      for (int i = 0; i < len; i++) begin
        e = (wr0 && i == 0 && p > 0) ? new0 : tbl[i];
        d = (e[23:16] == 8'd0) ? 1 : int'(e[23:16]);
        for (int c = 0; c < d * TICK_DIV; c++)
          expq.push_back({e[15:0], e[15:0] != 16'd0, 1'b1, 1'b0});
        for (int c = 0; c < GAP_TICKS * TICK_DIV; c++)
          expq.push_back({e[15:0], 1'b0, 1'b1, 1'b0});
      end
`ifndef TONE_SEQ_LOOP_EN
    expq.push_back({16'd0, 1'b0, 1'b0, 1'b1});
    expq.push_back({16'd0, 1'b0, 1'b0, 1'b0});
`endif
  endfunction

  // wr_k >= 0: rewrite entry 0 during note 0; st_k >= 0: extra start while busy.
  task automatic play_check(input string tag, input int num, input int wr_k,
                            input logic [23:0] wr_d, input int st_k);
    build_model(num, wr_k >= 0, wr_d);
    num_notes_i = 5'(num); start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < expq.size(); k++) begin
      chk($sformatf("%s k=%0d", tag, k), obs(), expq[k]);
      if (k == wr_k) begin wr_en_i = 1'b1; wr_addr_i = '0; wr_data_i = wr_d; end
      if (k == st_k) begin start_i = 1'b1; num_notes_i = 5'd1; end
      step();
      wr_en_i = 1'b0; start_i = 1'b0;
    end
`ifdef TONE_SEQ_LOOP_EN
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk({tag, " loop stop"}, obs(), 19'd0);
`endif
    if (wr_k >= 0) tbl[0] = wr_d;
  endtask

  task automatic rand_table();
    logic [15:0] p;
    for (int i = 0; i < DEPTH; i++) begin
      p = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      wr(i, {8'($urandom_range(0, 3)), p});
    end
  endtask

  initial begin
    rst_n_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    num_notes_i = '0; start_i = 1'b0; stop_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset state", obs(), 19'd0);
    rst_n_i = 1'b1;
    step();
    chk("idle after reset", obs(), 19'd0);

    wr(0, {8'd2, 16'd50});
    wr(1, {8'd1, 16'd80});
    play_check("two-note", 2, -1, 24'd0, -1);
    play_check("write-during-note", 2, 1, {8'd1, 16'd999}, 2);

    wr(0, {8'd3, 16'd0});
    wr(1, {8'd0, 16'd120});
    play_check("rest-dur0", 2, -1, 24'd0, -1);

    wr(0, {8'd2, 16'd50});
    wr(1, {8'd1, 16'd80});
    num_notes_i = 5'd2; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("pre-stop k=%0d", k), obs(), {16'd50, 1'b1, 1'b1, 1'b0});
      step();
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("after stop %0d", k), obs(), 19'd0);
      step();
    end
    play_check("replay after stop", 2, -1, 24'd0, -1);

    num_notes_i = 5'd0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("num0 start", obs(), 19'd0);
    step();
    chk("num0 start +1", obs(), 19'd0);

    num_notes_i = 5'd2; start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    chk("start+stop", obs(), 19'd0);
    step();
    chk("start+stop +1", obs(), 19'd0);

    rand_table();
    play_check("num31", 31, -1, 24'd0, -1);

    for (int it = 0; it < 4; it++) begin
      rand_table();
      play_check($sformatf("rand%0d", it), int'($urandom_range(1, 20)),
                 (it % 2 == 0) ? 1 : -1, {8'($urandom_range(0, 3)), 16'($urandom_range(1, 65535))},
                 (it % 2 == 1) ? 3 : -1);
    end

    wr(0, {8'd2, 16'd50});
    num_notes_i = 5'd1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    chk("pre-reset playing", obs(), {16'd50, 1'b1, 1'b1, 1'b0});
    #2 rst_n_i = 1'b0;
    #1 chk("async reset mid-play", obs(), 19'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();
    chk("idle after async reset", obs(), 19'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Upstream driver for the square-wave tone generator. Supplies its `ena` and `prescaler` inputs from a small writable note table.
- Steps through the table, one note after another. Each note holds its prescaler for a programmed number of time ticks, followed by a fixed silent gap.
- Sits between the control/UI logic, which loads notes and issues start/stop, and the tone generator, which drives the buzzer pin.

Parameters:
- DEPTH, 16, number of note-table entries.
- ADDR_W, 4, note-table address width; DEPTH = 2**ADDR_W.
- TICK_DIV, 100000, clk cycles per time tick (1 ms at 100 MHz); must be ≥ 1.
- GAP_TICKS, 10, silent ticks after every note; 0 means no gap.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  note-table write strobe.
- wr_addr  in  ADDR_W  note-table write address.
- wr_data  in  24  note entry {dur[7:0], presc[15:0]}; presc=0 denotes a rest.
- num_notes  in  ADDR_W+1  sequence length, sampled on start.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- prescaler  out  16  to tone generator `prescaler`; registered.
- tone_ena  out  1  to tone generator `ena`; registered.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse on normal sequence completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE; prescaler=0, tone_ena=0, busy=0, done=0; idx, tick and dur counters 0. The note table is not reset.
- Note table: register array.
  - Write on clk when wr_en=1, in any state.
  - Read combinationally at idx.
  - A write to the entry currently playing does not alter the note in progress; the entry is latched on note entry.
- States: IDLE, PLAY, GAP.
- IDLE:
  - start=1 and num_notes≠0 → latch len = min(num_notes, DEPTH), idx=0, load entry 0, go to PLAY.
  - start with num_notes=0 is ignored.
- Note entry (one cycle):
  - Latch presc and dur; dur=0 is treated as 1.
  - Next cycle: prescaler=presc, tone_ena=(presc≠0).
  - Latency: start sampled at cycle N → tone_ena high at N+1.
- Tick counter: counts 0..TICK_DIV-1, wraps to 0, and raises an internal tick on the wrap. Cleared on every note entry and every gap entry.
- PLAY: count ticks; after dur ticks (dur×TICK_DIV cycles of tone_ena high) →
  - GAP, with tone_ena=0 and prescaler held, if GAP_TICKS>0;
  - otherwise advance directly.
- GAP: after GAP_TICKS ticks → advance.
- Advance:
  - idx<len-1 → idx+1, note entry, PLAY.
  - idx=len-1 → IDLE, tone_ena=0, prescaler=0, done=1 for one cycle.
- stop=1 in any non-IDLE state → IDLE next cycle; tone_ena=0, prescaler=0, no done pulse.
- Simultaneous events:
  - stop and start in the same cycle: stop wins, start is ignored.
  - start while busy is ignored.
  - stop in IDLE has no effect.
- busy is asserted from the cycle after an accepted start until the cycle IDLE is re-entered.

Optional Feature:
- Macro: TONE_SEQ_LOOP_EN.
- Defined: reaching idx=len-1 wraps idx to 0 and continues playing indefinitely. done never pulses; only stop returns the block to IDLE.
- Undefined: single pass, as described in Behaviour.

Test Plan (bench uses TICK_DIV=4, GAP_TICKS=1, DEPTH=16):
- Reset check: assert rst_n=0 mid-PLAY → prescaler=0, tone_ena=0, busy=0 immediately, with no clk edge required.
- Two-note pass:
  - Stimulus: write entry0={2,16'd50}, entry1={1,16'd80}; num_notes=2; start.
  - prescaler=50 with tone_ena=1 for 8 cycles, then 4 cycles tone_ena=0.
  - prescaler=80 with tone_ena=1 for 4 cycles, then 4 cycles gap.
  - done pulses once; busy falls.
- Rest and dur=0:
  - entry0={3,16'd0} → tone_ena stays 0 for 12 cycles.
  - entry1={0,16'd120} → tone_ena high for 4 cycles, same as dur=1.
- Stop mid-note: stop during the second tick of note 0 → tone_ena=0 and busy=0 next cycle; no done; a new start replays from idx 0.
- Boundaries:
  - num_notes=0 with start → busy stays 0.
  - start+stop in the same cycle → no playback.
  - num_notes=31 → plays exactly 16 entries.
- Loop build (TONE_SEQ_LOOP_EN): num_notes=2 → prescaler sequence 50, 80, 50, 80… with no done pulse until stop is applied.
